seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DW, default 16, dividend/quotient width (>=2).
REQ-002 SHALL have parameter VW, default 8, divisor/remainder width (2..DW).
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port Start  input  1  request valid; operands sampled when Start&&InReady.
REQ-006 SHALL have port InReady  output  1  high only in IDLE.
REQ-007 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-008 SHALL have port Dividend  input  DW  dividend.
REQ-009 SHALL have port Divisor  input  VW  divisor.
REQ-010 SHALL have port OutValid  output  1  result valid, high only in DONE.
REQ-011 SHALL have port OutReady  input  1  consumer accepts result when OutValid&&OutReady.
REQ-012 SHALL have port Quotient  output  DW  quotient, registered.
REQ-013 SHALL have port Remainder  output  VW  remainder, registered.
REQ-014 SHALL have port DivByZero  output  1  divisor was zero; valid with OutValid.
REQ-015 SHALL have port Overflow  output  1  signed quotient not representable; valid with OutValid.
REQ-016 SHALL have port Busy  output  1  high in CALC or DONE.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-018 IDLE: on Start&&InReady SHALL latch operands/mode, convert signed operands to magnitudes, load counter = DW, go CALC; Start otherwise ignored.
REQ-019 Divisor == 0 at acceptance SHALL skip CALC, go DONE next edge: Quotient all ones, Remainder = 0, DivByZero = 1, Overflow = 0.
REQ-020 CALC SHALL perform one restoring step per cycle on a VW+1-bit partial remainder: shift in next dividend MSB, trial-subtract divisor magnitude, keep if non-negative (quotient bit 1) else restore (bit 0).
REQ-021 After exactly DW CALC cycles SHALL go DONE; OutValid rises DW+1 edges after the accepting edge.
REQ-022 Signed mode: quotient negated iff operand signs differ; remainder takes dividend sign (truncating division); Dividend = Quotient*Divisor + Remainder holds.
REQ-023 Signed most-negative Dividend / -1 SHALL give Quotient = most-negative value (wrap) and Overflow = 1.
REQ-024 Unsigned mode: Overflow always 0.
REQ-025 DONE SHALL hold Quotient, Remainder, flags stable until OutValid&&OutReady, then go IDLE on that edge.
REQ-026 Start during CALC/DONE SHALL be ignored, never corrupt the running operation.
REQ-027 Back-to-back: new request accepted no earlier than the cycle after the result handshake.

Reset
REQ-028 Rst high SHALL asynchronously force IDLE, InReady = 1, OutValid = 0, Busy = 0, Quotient = 0, Remainder = 0, DivByZero = 0, Overflow = 0, counter = 0.
REQ-029 Rst mid-CALC or mid-DONE SHALL abort the operation with no OutValid pulse; first request after Rst deasserts is accepted normally.

Structure
REQ-030 State encoding (IDLE, CALC, DONE) and default DW/VW SHALL live in shared package div_pkg.
REQ-031 One restoring iteration SHALL be a combinational sub-module div_step (inputs partial remainder, next bit, divisor magnitude; outputs new partial remainder, quotient bit).
REQ-032 Counter width SHALL be $clog2(DW+1); no other sub-modules.

Verification
REQ-033 Unsigned 36 / 7, OutReady=1 -> after 17 edges OutValid=1, Quotient=5, Remainder=1, flags 0.
REQ-034 Unsigned 781 / 6 -> Quotient=130, Remainder=1; Start pulsed during CALC with other operands -> result unchanged.
REQ-035 Signed -463 / 5 -> Quotient=-92 (0xFFA4), Remainder=-3 (0xFD); signed 463 / -5 -> Quotient=-92, Remainder=3.
REQ-036 Divisor 0, Dividend 1234 -> OutValid 2 edges after accept, Quotient=0xFFFF, Remainder=0, DivByZero=1.
REQ-037 Signed 0x8000 / 0xFF -> Quotient=0x8000, Overflow=1; OutReady held low 10 cycles -> outputs stable, OutValid held.
REQ-038 Rst asserted at CALC cycle 5 -> all outputs reset values immediately, no OutValid; then 100 / 9 -> Quotient=11, Remainder=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding and
// default operand widths.
package div_pkg;

  localparam int unsigned DefDW = 16;
  localparam int unsigned DefVW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the
// divisor magnitude and keep the difference only when it does not go negative.
module div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   rem_o,
  output logic          q_bit_o
);

  logic [VW:0] shifted;
  logic [VW:0] diff;
  logic        unused_rem_msb;

  // The incoming partial remainder is always below the divisor, so its top bit is zero.
  assign unused_rem_msb = rem_i[VW];
  assign shifted        = {rem_i[VW-1:0], bit_i};
  assign diff           = shifted - {1'b0, dvs_i};
  assign q_bit_o        = (shifted >= {1'b0, dvs_i});
  assign rem_o          = q_bit_o ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: one restoring step per clock on operand
// magnitudes, sign fix-up applied when the final step completes.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DefDW,
  parameter int unsigned VW = DefVW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  output logic          InReady,
  input  logic          Signed,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [DW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          DivByZero,
  output logic          Overflow,
  output logic          Busy
);

  localparam int unsigned CW = $clog2(DW + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW:0]   rem_q;
  logic [VW-1:0] dvs_q;
  logic          sgn_q, negq_q, negr_q, zero_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rmd_q;
  logic          dbz_q, ovf_q;

  logic [DW-1:0] dvd_mag, q_mag, q_fin;
  logic [VW-1:0] dvs_mag, r_mag, r_fin;
  logic [VW:0]   step_rem;
  logic          step_q;
  logic          ovf_fin;

  div_step #(
    .VW(VW)
  ) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[DW-1]),
    .dvs_i   (dvs_q),
    .rem_o   (step_rem),
    .q_bit_o (step_q)
  );

  always_comb begin
    dvd_mag = (Signed && Dividend[DW-1]) ? -Dividend : Dividend;
    dvs_mag = (Signed && Divisor[VW-1]) ? -Divisor : Divisor;
    // The dividend register doubles as the quotient shift register.
    q_mag   = {dvd_q[DW-2:0], step_q};
    r_mag   = step_rem[VW-1:0];
    q_fin   = negq_q ? -q_mag : q_mag;
    r_fin   = negr_q ? -r_mag : r_mag;
    // Only a positive signed result can exceed the representable range.
    ovf_fin = sgn_q && !negq_q && q_mag[DW-1];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            sgn_q   <= Signed;
            negq_q  <= Signed && (Dividend[DW-1] ^ Divisor[VW-1]);
            negr_q  <= Signed && Dividend[DW-1];
            zero_q  <= (Divisor == '0);
            dvd_q   <= dvd_mag;
            dvs_q   <= dvs_mag;
            rem_q   <= '0;
            cnt_q   <= CW'(DW);
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (zero_q) begin
            quo_q   <= '1;
            rmd_q   <= '0;
            dbz_q   <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            dvd_q <= q_mag;
            rem_q <= step_rem;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              quo_q   <= q_fin;
              rmd_q   <= r_fin;
              dbz_q   <= 1'b0;
              ovf_q   <= ovf_fin;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (OutReady) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign InReady   = (state_q == StIdle);
  assign OutValid  = (state_q == StDone);
  assign Busy      = (state_q != StIdle);
  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign DivByZero = dbz_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0;
  logic          Signed = 1'b0;
  logic          OutReady = 1'b0;
  logic [DW-1:0] Dividend = '0;
  logic [VW-1:0] Divisor = '0;
  logic          InReady, OutValid, DivByZero, Overflow, Busy;
  logic [DW-1:0] Quotient;
  logic [VW-1:0] Remainder;

  seq_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .InReady   (InReady),
    .Signed    (Signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .Overflow  (Overflow),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            acc;
    int            lat;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hold_low = 1'b0;
  bit   first_seen = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Truncating division semantics straight from the integer definition.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit s);
    exp_t e;
    int   sa, sb;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.acc = 0; e.lat = DW; e.name = "";
    if (b == '0) begin
      e.q = '1; e.dbz = 1'b1; e.lat = 1;
    end else if (!s) begin
      e.q = a / DW'(b);
      e.r = VW'(a % DW'(b));
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(2 ** (DW - 1)) && sb == -1) begin
        e.q   = DW'(sa);
        e.ovf = 1'b1;
      end else begin
        e.q = DW'(sa / sb);
        e.r = VW'(sa % sb);
      end
    end
    return e;
  endfunction

  // OutReady randomly stalls unless a test forces it low.
  initial forever begin
    @(negedge Clk);
    #1;
    OutReady = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented result against the head of the scoreboard.
  initial forever begin
    @(negedge Clk);
    #2;
    if (Rst) begin
      first_seen = 1'b0;
    end else if (OutValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got OutValid=1, expected no result pending");
      end else begin
        if (!first_seen) begin
          check({exp_q[0].name, "_latency"}, cyc - exp_q[0].acc, exp_q[0].lat);
          first_seen = 1'b1;
        end
        check({exp_q[0].name, "_quotient"}, 32'(Quotient), 32'(exp_q[0].q));
        check({exp_q[0].name, "_remainder"}, 32'(Remainder), 32'(exp_q[0].r));
        check({exp_q[0].name, "_divbyzero"}, 32'(DivByZero), 32'(exp_q[0].dbz));
        check({exp_q[0].name, "_overflow"}, 32'(Overflow), 32'(exp_q[0].ovf));
        check({exp_q[0].name, "_busy"}, 32'({Busy, InReady}), 32'h2);
        if (OutReady) begin
          void'(exp_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit s,
                     input string name, input bit garbage);
    exp_t e;
    int   t;
    t = 0;
    @(negedge Clk);
    while (!InReady && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!InReady) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got InReady=0, expected 1 within 200 cycles", name);
      return;
    end
    Dividend = a;
    Divisor  = b;
    Signed   = s;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    e      = model(a, b, s);
    e.acc  = cyc;
    e.name = name;
    exp_q.push_back(e);
    @(negedge Clk);
    if (garbage && e.lat > 1) begin
      repeat (3) begin
        Start    = 1'b1;
        Dividend = DW'($urandom);
        Divisor  = VW'($urandom);
        Signed   = 1'($urandom);
        @(negedge Clk);
      end
    end
    Start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge Clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    bit s;

    #1 Rst = 1'b1;
    #1;
    check("rst_inready", 32'(InReady), 32'h1);
    check("rst_outputs", {Quotient, Remainder, OutValid, Busy, DivByZero, Overflow}, 32'h0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    run(16'd36, 8'd7, 1'b0, "u36_7", 1'b0);
    run(16'd781, 8'd6, 1'b0, "u781_6", 1'b1);
    run(16'hFE31, 8'd5, 1'b1, "sm463_5", 1'b1);
    run(16'd463, 8'hFB, 1'b1, "s463_m5", 1'b0);
    run(16'd1234, 8'd0, 1'b0, "dbz1234", 1'b0);
    drain();

    hold_low = 1'b1;
    run(16'h8000, 8'hFF, 1'b1, "sovf", 1'b0);
    repeat (DW + 10) @(negedge Clk);
    #3;
    check("sovf_valid_held", 32'(OutValid), 32'h1);
    hold_low = 1'b0;
    drain();

    run(16'd5000, 8'd3, 1'b0, "aborted", 1'b0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_inready", 32'(InReady), 32'h1);
    check("midrst_outputs",
          {Quotient, Remainder, OutValid, Busy, DivByZero, Overflow}, 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      #3;
      if (OutValid) saw = 1'b1;
    end
    check("no_valid_after_rst", 32'(saw), 32'h0);
    run(16'd100, 8'd9, 1'b0, "u100_9", 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      a = DW'($urandom);
      b = VW'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) begin
        a = 16'h8000;
        b = 8'hFF;
        s = 1'b1;
      end
      run(a, b, s, $sformatf("rnd%0d", i), 1'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
